seg_scan_driver: RTL and testbench

Downstream display stage of the counter/stopwatch controller: takes the 8-digit hex value from the counting logic (32-bit `display` word) plus per-digit decimal points and time-multiplexes it onto the 8-digit common-anode 7-segment module. It runs a fixed scan rotation and inserts an all-off dead-time between digits to suppress ghosting. It also takes a per-frame snapshot so a digit never tears mid-frame. Its outputs drive the board pins `led_en` and `led_cx` directly.

---
 rtl/seg_scan_driver.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with per-frame snapshot and dead-time.
// Optional build macro SEG_ZERO_BLANK_EN enables leading-zero blanking of digits 1..7.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | display disabled, all digits and segments dark
// SHOW  | digit idx selected, segments decoded from the frame snapshot
// GAP   | all-off dead-time between two digits

module seg_scan_driver #(
    parameter int time_max = 100_000 - 1,
    parameter int GAP_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] display,
    input  logic [7:0]  dp,
    output logic [7:0]  led_en,
    output logic [7:0]  led_cx
);

    localparam int DW = (time_max > 0) ? $clog2(time_max + 1) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(time_max);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    idx, idx_nx;
    logic [DW-1:0] dwell_cnt, dwell_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [31:0]   snap_disp, snap_disp_nx;
    logic [7:0]    snap_dp, snap_dp_nx;
    logic [7:0]    led_en_nx, led_cx_nx;
    logic [3:0]    nibble;

    function automatic logic [7:0] font(input logic [3:0] n);
        logic [7:0] seg;
        case (n)
            4'h0:    seg = 8'h03;
            4'h1:    seg = 8'h9F;
            4'h2:    seg = 8'h25;
            4'h3:    seg = 8'h0D;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h49;
            4'h6:    seg = 8'h41;
            4'h7:    seg = 8'h1F;
            4'h8:    seg = 8'h01;
            4'h9:    seg = 8'h09;
            4'hA:    seg = 8'h11;
            4'hB:    seg = 8'hC1;
            4'hC:    seg = 8'h63;
            4'hD:    seg = 8'h85;
            4'hE:    seg = 8'h61;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

`ifdef SEG_ZERO_BLANK_EN
    // Digit i is a leading zero when it and every more-significant nibble are zero.
    function automatic logic is_blank(input logic [31:0] d, input logic [2:0] i);
        logic [31:0] upper;
        upper = d >> {i, 2'b00};
        return (i != 3'd0) && (upper == 32'd0);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            snap_disp <= 32'd0;
            snap_dp   <= 8'd0;
            led_en    <= 8'hFF;
            led_cx    <= 8'hFF;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            dwell_cnt <= dwell_nx;
            gap_cnt   <= gap_nx;
            snap_disp <= snap_disp_nx;
            snap_dp   <= snap_dp_nx;
            led_en    <= led_en_nx;
            led_cx    <= led_cx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        dwell_nx     = dwell_cnt;
        gap_nx       = gap_cnt;
        snap_disp_nx = snap_disp;
        snap_dp_nx   = snap_dp;

        if (!en) begin
            state_nx = IDLE;
            idx_nx   = 3'd0;
            dwell_nx = '0;
            gap_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx     = SHOW;
                    idx_nx       = 3'd0;
                    dwell_nx     = '0;
                    gap_nx       = '0;
                    snap_disp_nx = display;
                    snap_dp_nx   = dp;
                end
                SHOW: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_nx = '0;
                        if (GAP_LEN > 0) begin
                            state_nx = GAP;
                            gap_nx   = '0;
                        end else begin
                            idx_nx = idx + 3'd1;
                            if (idx == 3'd7) begin
                                snap_disp_nx = display;
                                snap_dp_nx   = dp;
                            end
                        end
                    end else begin
                        dwell_nx = dwell_cnt + DW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nx = SHOW;
                        gap_nx   = '0;
                        idx_nx   = idx + 3'd1;
                        // Wrapping back to digit 0 starts a new frame.
                        if (idx == 3'd7) begin
                            snap_disp_nx = display;
                            snap_dp_nx   = dp;
                        end
                    end else begin
                        gap_nx = gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = 3'd0;
                    dwell_nx = '0;
                    gap_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so the pins are registered without extra latency.
    assign nibble = snap_disp_nx[{idx_nx, 2'b00} +: 4];

    always_comb begin
        led_en_nx = 8'hFF;
        led_cx_nx = 8'hFF;
        if (state_nx == SHOW) begin
            led_en_nx = ~(8'b1 << idx_nx);
            led_cx_nx = font(nibble);
            if (snap_dp_nx[idx_nx])
                led_cx_nx[0] = 1'b0;
`ifdef SEG_ZERO_BLANK_EN
            if (is_blank(snap_disp_nx, idx_nx))
                led_cx_nx = 8'hFF;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed phases plus random traffic against a
// position-in-frame reference model (honours SEG_ZERO_BLANK_EN when defined).

module tb_seg_scan_driver;

    localparam int TM    = 9;
    localparam int GL    = 2;
    localparam int SLOT  = TM + 1 + GL;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] display = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;

    int checks = 0;
    int failures = 0;

    // reference model: scan position counted from the first SHOW cycle
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [31:0] m_snap = 32'd0;
    logic [7:0]  m_sdp = 8'd0;
    logic [7:0]  font_tab [16];

    seg_scan_driver #(.time_max(TM), .GAP_LEN(GL)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .display(display),
        .dp     (dp),
        .led_en (led_en),
        .led_cx (led_cx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_en, e_cx;
        int dig, slot;
        logic [31:0] upper;
        e_en = 8'hFF;
        e_cx = 8'hFF;
        if (m_active) begin
            slot = m_t % SLOT;
            dig  = (m_t / SLOT) % 8;
            if (slot <= TM) begin
                e_en = 8'hFF;
                e_en[dig] = 1'b0;
                upper = m_snap >> (4 * dig);
                e_cx = font_tab[upper[3:0]];
                if (m_sdp[dig]) e_cx[0] = 1'b0;
`ifdef SEG_ZERO_BLANK_EN
                if (dig != 0 && upper == 32'd0) e_cx = 8'hFF;
`endif
            end
        end
        check_eq("led_en", led_en, e_en);
        check_eq("led_cx", led_cx, e_cx);
    endtask

    task automatic step();
        logic r, e;
        logic [31:0] d;
        logic [7:0] p;
        r = rst; e = en; d = display; p = dp;
        @(posedge clk);
        if (r || !e) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t = 0;
            m_snap = d;
            m_sdp = p;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                m_snap = d;
                m_sdp = p;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // advance until the model reaches a given position within the frame
    task automatic run_to(input int pos);
        int budget;
        budget = 0;
        while (!(m_active && (m_t % FRAME) == pos) && budget < 2 * FRAME) begin
            step();
            budget++;
        end
        checks++;
        if (budget >= 2 * FRAME) begin
            failures++;
            $error("FAIL run_to pos=%0d observed=timeout expected=reached", pos);
        end
    endtask

    initial begin
        font_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                     8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

        // reset with enable low
        rst = 1'b1; en = 1'b0;
        run(2);
        check_eq("reset_en", led_en, 8'hFF);
        check_eq("reset_cx", led_cx, 8'hFF);
        rst = 1'b0;
        run(4);

        // basic scan
        display = 32'h8765_4321; dp = 8'h00; en = 1'b1;
        step();
        check_eq("first_en", led_en, 8'hFE);
        check_eq("first_cx", led_cx, 8'h9F);
        run(FRAME + 2 * SLOT);

        // snapshot: change display during digit 3
        run_to(3 * SLOT + 4);
        display = 32'hFFFF_FFFF;
        run_to(4 * SLOT + 1);
        check_eq("snap_d4", led_cx, 8'h49);
        run(FRAME + SLOT);

        // enable drop mid digit-5 dwell, then re-enable
        run_to(5 * SLOT + 4);
        en = 1'b0;
        step();
        check_eq("drop_en", led_en, 8'hFF);
        check_eq("drop_cx", led_cx, 8'hFF);
        run(3);
        en = 1'b1;
        step();
        check_eq("reen_en", led_en, 8'hFE);
        run(2 * SLOT);

        // decimal point on digit 2
        dp = 8'h04; display = 32'd0;
        run_to(0);
        run_to(2 * SLOT + 3);
        check_eq("dp2_cx", led_cx, 8'h02);
        run(FRAME);

        // leading zeros
        dp = 8'h00; display = 32'h0000_0013;
        run_to(0);
        run(FRAME);

        // reset mid-GAP and mid-SHOW
        run_to(3 * SLOT + TM + 1);
        rst = 1'b1;
        step();
        check_eq("rst_gap_en", led_en, 8'hFF);
        rst = 1'b0;
        run(SLOT);
        run_to(6 * SLOT + 2);
        rst = 1'b1;
        step();
        check_eq("rst_show_cx", led_cx, 8'hFF);
        rst = 1'b0;
        run(2 * SLOT);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) display = $urandom;
            if ($urandom_range(0, 39) == 0) dp = 8'($urandom);
            if ($urandom_range(0, 3) == 0) display[31:16] = 16'd0;
            if ($urandom_range(0, 149) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
